// File: rtl/manchester_rx_framer.sv
// Manchester receive framer: oversampled bit recovery, sync hunt, AXI-Stream words.
// Optional MANCHESTER_RX_STATS_EN adds saturating frame counters.
module manchester_rx_framer #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_WORDS = 64,
  parameter int SYNC_WIDTH = 16,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 16'hAAD5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  manchester_in,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  sync_locked,
  output logic                  overflow
`ifdef MANCHESTER_RX_STATS_EN
  ,
  output logic [15:0]           frames_ok,
  output logic [15:0]           frames_aborted,
  output logic [15:0]           frames_dropped
`endif
);

  localparam int TW = $clog2(2 * OVERSAMPLE + 1);
  localparam logic [TW-1:0] T_SAT = TW'(2 * OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'((3 * OVERSAMPLE) / 4);
  localparam logic [TW-1:0] T_LOS = TW'((3 * OVERSAMPLE) / 2);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam logic [WW-1:0] W_LAST = WW'(FRAME_WORDS - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic {HUNT, DATA} state_t;

  state_t state, state_n;

  logic s1, s2, line_q;
  logic [TW-1:0] timer;
  logic line_edge, accept;
  logic bit_valid, bit_val, los_q;

  logic [SYNC_WIDTH-2:0] sync_sr;
  logic [DATA_WIDTH-2:0] word_sr;
  logic [SYNC_WIDTH-1:0] sync_full;
  logic [DATA_WIDTH-1:0] word_full;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic drop;

  logic push_req, push_last, push_user;
  logic [DATA_WIDTH-1:0] push_word;
  logic abort, word_done;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, fill;
  logic pop, full, push_ok, load;

  assign line_edge = s2 ^ line_q;
  assign accept = line_edge && (timer >= T_MID || timer == T_SAT);
  assign sync_full = {sync_sr, bit_val};
  assign word_full = {word_sr, bit_val};
  assign sync_locked = (state == DATA);

  assign pop = m_axis_tvalid && m_axis_tready;
  assign fill = cnt + {{AW{1'b0}}, m_axis_tvalid};
  assign full = (fill == DEPTH);
  assign push_ok = push_req && (!full || pop);
  assign load = (cnt != '0) && (!m_axis_tvalid || pop);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= HUNT;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    push_req = 1'b0;
    push_word = '0;
    push_last = 1'b0;
    push_user = 1'b0;
    abort = 1'b0;
    word_done = 1'b0;
    unique case (state)
      HUNT: begin
        if (bit_valid && sync_full == SYNC_PATTERN)
          state_n = DATA;
      end
      DATA: begin
        if (los_q) begin
          abort = 1'b1;
          state_n = HUNT;
          if (word_cnt != '0 && !drop) begin
            push_req = 1'b1;
            push_last = 1'b1;
            push_user = 1'b1;
          end
        end else if (bit_valid && bit_cnt == B_LAST) begin
          word_done = 1'b1;
          push_req = !drop;
          push_word = word_full;
          push_last = (word_cnt == W_LAST);
          if (word_cnt == W_LAST)
            state_n = HUNT;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      line_q <= 1'b0;
      timer <= T_SAT;
      bit_valid <= 1'b0;
      bit_val <= 1'b0;
      los_q <= 1'b0;
      sync_sr <= '0;
      word_sr <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      drop <= 1'b0;
      overflow <= 1'b0;
    end else begin
      s1 <= manchester_in;
      s2 <= s1;
      line_q <= s2;
      if (accept)             timer <= '0;
      else if (timer != T_SAT) timer <= timer + 1'b1;
      bit_valid <= accept;
      bit_val <= s2;
      los_q <= (timer == T_LOS) && !accept;
      if (state == HUNT) begin
        if (bit_valid) sync_sr <= sync_full[SYNC_WIDTH-2:0];
        bit_cnt <= '0;
        word_cnt <= '0;
        drop <= 1'b0;
      end else begin
        if (bit_valid) begin
          word_sr <= word_full[DATA_WIDTH-2:0];
          bit_cnt <= (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
        end
        if (word_done) word_cnt <= word_cnt + 1'b1;
        if (push_req && !push_ok) drop <= 1'b1;
        if (state_n == HUNT) sync_sr <= '0;
      end
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage is the memory plus the output register; together they hold FIFO_DEPTH words
  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr] <= {push_word, push_last, push_user};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, load};
      if (load) begin
        {m_axis_tdata, m_axis_tlast, m_axis_tuser} <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (pop) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef MANCHESTER_RX_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frames_ok <= '0;
      frames_aborted <= '0;
      frames_dropped <= '0;
    end else begin
      if (push_ok && push_last && !push_user && frames_ok != '1)
        frames_ok <= frames_ok + 1'b1;
      if (abort && frames_aborted != '1)
        frames_aborted <= frames_aborted + 1'b1;
      if (state == DATA && push_req && !push_ok && !drop &&
          frames_dropped != '1)
        frames_dropped <= frames_dropped + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_manchester_rx_framer.sv
// Scoreboard bench for manchester_rx_framer with default parameters.
// Directed frames: clean, abort, stall, jitter/glitch, overflow, mid-frame reset.
module tb_manchester_rx_framer;

  localparam int FW = 64;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic manchester_in = 1'b0;
  logic m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic sync_locked, overflow;

  manchester_rx_framer dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .manchester_in(manchester_in),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .sync_locked(sync_locked),
    .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] d;
    logic l;
    logic u;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_e;
  int total = 0;
  int bad = 0;
  bit jit_on = 0;
  bit glitch_on = 0;
  int jcnt = 0;
  event mid_evt;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [7:0] d, input logic l, input logic u);
    beat_t e;
    e.d = d;
    e.l = l;
    e.u = u;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v, input int n);
    manchester_in = v;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input bit mark);
    int h2;
    h2 = 4;
    if (jit_on) begin
      h2 = (jcnt % 4 == 0 || jcnt % 4 == 3) ? 5 : 3;
      jcnt++;
    end
    drive(~b, 4);
    manchester_in = b;
    if (mark) ->mid_evt;
    if (glitch_on) begin
      drive(b, 2);
      drive(~b, 1);
      drive(b, h2 - 3);
    end else begin
      drive(b, h2);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit mark);
    for (int i = 7; i >= 0; i--)
      send_bit(v[i], mark && (i == 0));
  endtask

  task automatic send_sync();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hD5, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] seed, input logic [7:0] step,
                            input int n_exp);
    logic [7:0] v;
    send_sync();
    for (int k = 0; k < FW; k++) begin
      v = seed + 8'(k) * step;
      if (k < n_exp) exp_push(v, k == FW - 1, 1'b0);
      send_byte(v, 1'b0);
    end
    drive(manchester_in, 40);
  endtask

  task automatic check_reset(input string p);
    check({p, "_tvalid"}, m_axis_tvalid, 0);
    check({p, "_tlast"}, m_axis_tlast, 0);
    check({p, "_tuser"}, m_axis_tuser, 0);
    check({p, "_tdata"}, m_axis_tdata, 0);
    check({p, "_locked"}, sync_locked, 0);
    check({p, "_overflow"}, overflow, 0);
  endtask

  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_extra: got data=%0h last=%0b user=%0b required none",
                 m_axis_tdata, m_axis_tlast, m_axis_tuser);
      end else begin
        got_e = exp_q.pop_front();
        check("beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
              {got_e.d, got_e.l, got_e.u});
      end
    end
  end

  initial begin
    @(mid_evt);
    repeat (4) @(posedge aclk);
    #1;
    check("latency_c4", m_axis_tvalid, 0);
    @(posedge aclk);
    #1;
    check("latency_c5", m_axis_tvalid, 1);
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    check_reset("init");
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    drive(1'b0, 4);

    send_frame(8'h00, 8'h01, FW);
    check("f1_unlocked", sync_locked, 0);
    check("f1_drained", exp_q.size(), 0);

    send_sync();
    exp_push(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA1, 1'b1);
    check("abort_locked", sync_locked, 1);
    exp_push(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0);
    exp_push(8'hA3, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b0);
    exp_push(8'h00, 1'b1, 1'b1);
    drive(manchester_in, 40);
    check("abort_unlocked", sync_locked, 0);
    check("abort_drained", exp_q.size(), 0);

    send_sync();
    @(posedge aclk);
    #1;
    check("stall_locked", sync_locked, 1);
    drive(manchester_in, 40);
    check("stall_unlocked", sync_locked, 0);
    check("stall_no_beat", m_axis_tvalid, 0);

    jit_on = 1;
    glitch_on = 1;
    send_frame(8'h5A, 8'h1D, FW);
    jit_on = 0;
    glitch_on = 0;
    check("jitter_drained", exp_q.size(), 0);

    m_axis_tready = 1'b0;
    send_frame(8'h80, 8'h01, 16);
    check("ovf_flag", overflow, 1);
    check("ovf_tvalid", m_axis_tvalid, 1);
    check("ovf_hold_data", m_axis_tdata, 8'h80);
    m_axis_tready = 1'b1;
    drive(manchester_in, 40);
    check("ovf_drained", exp_q.size(), 0);
    send_frame(8'h40, 8'h03, FW);
    check("post_ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);

    m_axis_tready = 1'b0;
    send_sync();
    for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k), 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    check_reset("midrst");
    m_axis_tready = 1'b1;
    drive(manchester_in, 20);
    check("midrst_empty", m_axis_tvalid, 0);
    send_frame(8'h33, 8'h07, FW);
    check("midrst_drained", exp_q.size(), 0);
    check("midrst_unlocked", sync_locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
